// File: rtl/fetch_pc_unit_pkg.sv
// fetch_pc_unit_pkg: shared exception codes and default address map for the fetch stage
package fetch_pc_unit_pkg;
  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;
  localparam logic [31:0] IM_LO_DEF = 32'h0000_3000;
  localparam logic [31:0] IM_HI_DEF = 32'h0000_6FFF;
endpackage

// File: rtl/fetch_addr_check.sv
// fetch_addr_check: word alignment plus inclusive unsigned range check
// ports: pc (address under test), fault (1 = misaligned or outside [LO, HI])
module fetch_addr_check #(
  parameter logic [31:0] LO = 32'h0000_3000,
  parameter logic [31:0] HI = 32'h0000_6FFF
) (
  input  logic [31:0] pc,
  output logic        fault
);
  assign fault = (pc[1:0] != 2'b00) || (pc < LO) || (pc > HI);
endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: fetch PC register, next-PC arbitration and the F-stage output bundle
// ports: clk/reset; Req, WrEn, D_eret/EPC, D_BranchTaken/D_BranchTarget redirect the PC;
// i_inst_addr/i_inst_rdata talk to instruction memory; F_* feed the F/D register
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF,
  parameter logic [31:0] IM_LO = IM_LO_DEF,
  parameter logic [31:0] IM_HI = IM_HI_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic        WrEn,
  input  logic        D_eret,
  input  logic [31:0] EPC,
  input  logic        D_BranchTaken,
  input  logic [31:0] D_BranchTarget,
  input  logic        D_IsBranchJump,
  output logic [31:0] i_inst_addr,
  input  logic [31:0] i_inst_rdata,
  output logic [31:0] F_PC,
  output logic [31:0] F_Instr,
  output logic        F_DelaySlot,
  output logic [4:0]  F_EXCCode
);
  logic [31:0] pc;
  logic fault;
  // Req outranks the stall so interrupts are taken even while the pipe is frozen
  always_ff @(posedge clk) begin
    if (reset) pc <= RESET_PC;
    else if (Req) pc <= HANDLER_PC;
    else if (WrEn) pc <= D_eret ? EPC : D_BranchTaken ? D_BranchTarget : pc + 32'd4;
  end
  fetch_addr_check #(.LO(IM_LO), .HI(IM_HI)) u_chk (.pc(pc), .fault(fault));
  // address still goes out on a fault; the returned word is masked to a nop
  assign i_inst_addr = pc;
  assign F_PC = pc;
  assign F_Instr = fault ? 32'd0 : i_inst_rdata;
  assign F_EXCCode = fault ? EXC_ADEL : EXC_NONE;
  assign F_DelaySlot = D_IsBranchJump;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: scoreboard bench for the fetch PC unit
module tb_fetch_pc_unit;
  logic clk = 1'b0;
  logic reset, Req, WrEn, D_eret, D_BranchTaken, D_IsBranchJump;
  logic [31:0] EPC, D_BranchTarget, i_inst_addr, i_inst_rdata, F_PC, F_Instr;
  logic F_DelaySlot;
  logic [4:0] F_EXCCode;
  int checks = 0;
  int errors = 0;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  exc;
    logic        ds;
  } exp_t;
  exp_t sb[$];
  fetch_pc_unit dut (
    .clk(clk), .reset(reset), .Req(Req), .WrEn(WrEn), .D_eret(D_eret), .EPC(EPC),
    .D_BranchTaken(D_BranchTaken), .D_BranchTarget(D_BranchTarget),
    .D_IsBranchJump(D_IsBranchJump), .i_inst_addr(i_inst_addr), .i_inst_rdata(i_inst_rdata),
    .F_PC(F_PC), .F_Instr(F_Instr), .F_DelaySlot(F_DelaySlot), .F_EXCCode(F_EXCCode)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction
  assign i_inst_rdata = mem(i_inst_addr);
  task automatic push(input logic [31:0] pc, input logic [4:0] exc);
    sb.push_back('{pc: pc, instr: (exc != 5'd0) ? 32'd0 : mem(pc), exc: exc, ds: D_IsBranchJump});
  endtask
  task automatic pop_check();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard empty");
      return;
    end
    e = sb.pop_front();
    if (F_PC !== e.pc) begin errors++; $display("FAIL F_PC got %h want %h", F_PC, e.pc); end
    checks++;
    if (i_inst_addr !== e.pc) begin errors++; $display("FAIL i_inst_addr got %h want %h", i_inst_addr, e.pc); end
    checks++;
    if (F_Instr !== e.instr) begin errors++; $display("FAIL F_Instr at %h got %h want %h", e.pc, F_Instr, e.instr); end
    checks++;
    if (F_EXCCode !== e.exc) begin errors++; $display("FAIL F_EXCCode at %h got %0d want %0d", e.pc, F_EXCCode, e.exc); end
    checks++;
    if (F_DelaySlot !== e.ds) begin errors++; $display("FAIL F_DelaySlot at %h got %b want %b", e.pc, F_DelaySlot, e.ds); end
  endtask
  task automatic cycle(input logic [31:0] pc, input logic [4:0] exc);
    push(pc, exc);
    @(posedge clk);
    #1;
    pop_check();
  endtask
  task automatic now(input logic [31:0] pc, input logic [4:0] exc);
    push(pc, exc);
    #1;
    pop_check();
  endtask
  task automatic test_reset();
    reset = 1; Req = 0; WrEn = 1; D_eret = 0; EPC = 0; D_BranchTaken = 0;
    D_BranchTarget = 0; D_IsBranchJump = 0;
    cycle(32'h3000, 0);
    cycle(32'h3000, 0);
    reset = 0;
    now(32'h3000, 0);
    cycle(32'h3004, 0);
    cycle(32'h3008, 0);
  endtask
  task automatic test_stall();
    WrEn = 0;
    for (int i = 0; i < 3; i++) cycle(32'h3008, 0);
    D_BranchTaken = 1; D_BranchTarget = 32'h3100;
    cycle(32'h3008, 0);
    WrEn = 1;
    cycle(32'h3100, 0);
    D_BranchTarget = 32'h3010;
    cycle(32'h3010, 0);
    D_BranchTaken = 0;
  endtask
  task automatic test_delay_slot();
    D_IsBranchJump = 1;
    now(32'h3010, 0);
    D_BranchTaken = 1; D_BranchTarget = 32'h3040;
    cycle(32'h3040, 0);
    D_IsBranchJump = 0; D_BranchTaken = 0;
    now(32'h3040, 0);
  endtask
  task automatic test_priority();
    Req = 1; WrEn = 0; D_eret = 1; EPC = 32'h3024; D_BranchTaken = 1; D_BranchTarget = 32'h3100;
    cycle(32'h4180, 0);
    Req = 0; WrEn = 1;
    cycle(32'h3024, 0);
    D_eret = 0; D_BranchTaken = 0;
    cycle(32'h3028, 0);
  endtask
  task automatic test_fault();
    D_eret = 1; EPC = 32'h3002;
    cycle(32'h3002, 4);
    D_eret = 0; D_BranchTaken = 1; D_IsBranchJump = 1;
    D_BranchTarget = 32'h7000; cycle(32'h7000, 4);
    D_BranchTarget = 32'h2FFC; cycle(32'h2FFC, 4);
    D_BranchTarget = 32'h6FFC; cycle(32'h6FFC, 0);
    D_BranchTaken = 0; D_IsBranchJump = 0;
    cycle(32'h7000, 4);
    D_BranchTaken = 1; D_BranchTarget = 32'h3000; cycle(32'h3000, 0);
    D_BranchTarget = 32'hFFFF_FFFC; cycle(32'hFFFF_FFFC, 4);
    D_BranchTaken = 0;
    cycle(32'h0000_0000, 4);
  endtask
  task automatic test_reset_mid();
    D_BranchTaken = 1; D_BranchTarget = 32'h5000;
    cycle(32'h5000, 0);
    reset = 1; Req = 1; WrEn = 0; D_eret = 1; EPC = 32'h3024;
    cycle(32'h3000, 0);
    reset = 0; Req = 0; WrEn = 1; D_eret = 0; D_BranchTaken = 0;
    cycle(32'h3004, 0);
  endtask
  initial begin
    test_reset();
    test_stall();
    test_delay_slot();
    test_priority();
    test_fault();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
